// File: rtl/fp_addsub_pipe.sv
// -----------------------------------------------------------------------------
// fp_addsub_pipe
//   Three-stage pipelined floating-point adder/subtractor. The format is
//   sign/exponent/mantissa with a hidden bit. Denormals are flushed to zero and
//   results are truncated toward zero. Every stage advances together under a
//   single valid/ready handshake. Special values (NaN, infinity, zero) are
//   resolved in stage 1 and bypass the arithmetic path.
//
//   Stage 1 : unpack, effective-sign fix-up, swap by magnitude, align little
//   Stage 2 : add or subtract aligned mantissas (never negative)
//   Stage 3 : normalise, truncate, pack, saturate/flush, raise flags
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   in_valid/ready  input handshake; in_ready is high whenever the pipe advances
//   in_a, in_b      operands {sign, exp, man}
//   in_sub          1: compute A-B (B sign inverted on entry)
//   in_tag          opaque tag, returned unchanged with the result
//   out_valid/ready output handshake
//   out_result      packed result
//   out_tag         tag of this result
//   out_overflow    finite inputs overflowed to infinity
//   out_underflow   nonzero result flushed to +0
//   out_invalid     NaN input or inf-inf; result is the canonical NaN
// -----------------------------------------------------------------------------
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic                   in_sub,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_result,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   out_overflow,
  output logic                   out_underflow,
  output logic                   out_invalid
);

  localparam int W    = 1 + EXP_W + MAN_W;
  // Aligned mantissa width: hidden bit + stored bits + 2 guard bits.
  localparam int MW   = MAN_W + 3;
  localparam int LZ_W = $clog2(MW);

  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [W-1:0]     QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic             spec;      // result fully decided in stage 1
    logic             inv;
    logic [W-1:0]     spec_res;
    logic             sign;      // sign of the larger-magnitude operand
    logic [EXP_W-1:0] exp;       // exponent of the larger-magnitude operand
    logic             eff_sub;   // effective signs differ
    logic [MW-1:0]    big;
    logic [MW-1:0]    lit;       // already aligned to big
  } s1_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic             spec;
    logic             inv;
    logic [W-1:0]     spec_res;
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MW:0]      sum;       // includes the carry bit
  } s2_t;

  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;

  logic             out_valid_q;
  logic [W-1:0]     out_result_q, res_d;
  logic [TAG_W-1:0] out_tag_q;
  logic             out_ovf_q, ovf_d;
  logic             out_unf_q, unf_d;
  logic             out_inv_q, inv_d;

  // The whole pipe moves as one: a stalled output freezes every stage.
  logic adv;
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  // ---------------------------------------------------------------------------
  // Stage 1: unpack, classify, swap, align
  // ---------------------------------------------------------------------------
  logic             a_s, b_s;
  logic [EXP_W-1:0] a_e, b_e, big_e, lit_e, d;
  logic [MAN_W-1:0] a_m, b_m, big_m, lit_m;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_big;

  assign a_s = in_a[W-1];
  assign b_s = in_b[W-1] ^ in_sub;
  assign a_e = in_a[W-2:MAN_W];
  assign b_e = in_b[W-2:MAN_W];
  assign a_m = in_a[MAN_W-1:0];
  assign b_m = in_b[MAN_W-1:0];

  // exp==0 covers both true zero and flushed denormals.
  assign a_zero = (a_e == '0);
  assign b_zero = (b_e == '0);
  assign a_inf  = (a_e == EXP_MAX) && (a_m == '0);
  assign b_inf  = (b_e == EXP_MAX) && (b_m == '0);
  assign a_nan  = (a_e == EXP_MAX) && (a_m != '0);
  assign b_nan  = (b_e == EXP_MAX) && (b_m != '0);

  // Magnitude compare on {exp, man}; ties keep A as the big operand.
  assign a_big = ({a_e, a_m} >= {b_e, b_m});
  assign big_e = a_big ? a_e : b_e;
  assign lit_e = a_big ? b_e : a_e;
  assign big_m = a_big ? a_m : b_m;
  assign lit_m = a_big ? b_m : a_m;
  assign d     = big_e - lit_e;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    s1_d          = '0;
    s1_d.valid    = in_valid;
    s1_d.tag      = in_tag;
    s1_d.sign     = a_big ? a_s : b_s;
    s1_d.exp      = big_e;
    s1_d.eff_sub  = a_s ^ b_s;
    s1_d.big      = {1'b1, big_m, 2'b00};
    s1_d.lit      = (int'(d) >= MW) ? '0 : ({1'b1, lit_m, 2'b00} >> d);
    s1_d.spec     = 1'b1;
    if (a_nan || b_nan) begin
      s1_d.spec_res = QNAN;
      s1_d.inv      = 1'b1;
    end else if (a_inf && b_inf) begin
      if (a_s != b_s) begin
        s1_d.spec_res = QNAN;
        s1_d.inv      = 1'b1;
      end else begin
        s1_d.spec_res = {a_s, EXP_MAX, {MAN_W{1'b0}}};
      end
    end else if (a_inf) begin
      s1_d.spec_res = {a_s, EXP_MAX, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      s1_d.spec_res = {b_s, EXP_MAX, {MAN_W{1'b0}}};
    end else if (a_zero && b_zero) begin
      // -0 only when both effective signs are negative.
      s1_d.spec_res = {a_s & b_s, {(W-1){1'b0}}};
    end else if (a_zero) begin
      s1_d.spec_res = {b_s, in_b[W-2:0]};
    end else if (b_zero) begin
      s1_d.spec_res = {a_s, in_a[W-2:0]};
    end else begin
      s1_d.spec = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: add / subtract. big >= little by construction, so no negation.
  // ---------------------------------------------------------------------------
  always_comb begin
    s2_d          = '0;
    s2_d.valid    = s1_q.valid;
    s2_d.tag      = s1_q.tag;
    s2_d.spec     = s1_q.spec;
    s2_d.inv      = s1_q.inv;
    s2_d.spec_res = s1_q.spec_res;
    s2_d.sign     = s1_q.sign;
    s2_d.exp      = s1_q.exp;
    s2_d.sum      = s1_q.eff_sub ? ({1'b0, s1_q.big} - {1'b0, s1_q.lit})
                                 : ({1'b0, s1_q.big} + {1'b0, s1_q.lit});
  end

  // ---------------------------------------------------------------------------
  // Stage 3: normalise, truncate, pack
  // ---------------------------------------------------------------------------
  function automatic logic [LZ_W-1:0] clz(input logic [MW-1:0] v);
    logic [LZ_W-1:0] n;
    // NOTE: blocking assignments here and in always_comb model combinational
    // evaluation order; registered state always uses non-blocking.
    n = '0;
    for (int i = 0; i < MW; i++) begin
      if (v[i]) n = LZ_W'(MW - 1 - i);
    end
    return n;
  endfunction

  logic [MW-1:0]    frac;
  logic [LZ_W-1:0]  lz;
  logic [EXP_W:0]   lz_ext, e_up, e_dn;
  logic [MAN_W-1:0] man_up, man_dn;

  assign frac   = s2_q.sum[MW-1:0];
  assign lz     = clz(frac);
  assign lz_ext = (EXP_W+1)'(lz);
  assign e_up   = {1'b0, s2_q.exp} + {{EXP_W{1'b0}}, 1'b1};
  assign e_dn   = {1'b0, s2_q.exp} - lz_ext;
  // Drop the hidden bit and the two guard bits (truncation).
  assign man_up = MAN_W'(s2_q.sum >> 3);
  assign man_dn = MAN_W'((frac << lz) >> 2);

  always_comb begin
    res_d = '0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    inv_d = 1'b0;
    if (s2_q.spec) begin
      res_d = s2_q.spec_res;
      inv_d = s2_q.inv;
    end else if (s2_q.sum == '0) begin
      res_d = '0;
    end else if (s2_q.sum[MW]) begin
      if (e_up >= {1'b0, EXP_MAX}) begin
        res_d = {s2_q.sign, EXP_MAX, {MAN_W{1'b0}}};
        ovf_d = 1'b1;
      end else begin
        res_d = {s2_q.sign, e_up[EXP_W-1:0], man_up};
      end
    end else if (lz_ext >= {1'b0, s2_q.exp}) begin
      // Renormalised exponent would be <= 0: flush to +0.
      res_d = '0;
      unf_d = 1'b1;
    end else begin
      res_d = {s2_q.sign, e_dn[EXP_W-1:0], man_dn};
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // NOTE: only the stage valid bits are reset; the wide datapath fields are
  // don't-care while valid is low and are left without reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q.valid <= 1'b0;
      s2_q.valid <= 1'b0;
    end else if (adv) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
      out_ovf_q    <= 1'b0;
      out_unf_q    <= 1'b0;
      out_inv_q    <= 1'b0;
    end else if (adv) begin
      out_valid_q  <= s2_q.valid;
      out_result_q <= res_d;
      out_tag_q    <= s2_q.tag;
      out_ovf_q    <= ovf_d;
      out_unf_q    <= unf_d;
      out_inv_q    <= inv_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_result    = out_result_q;
  assign out_tag       = out_tag_q;
  assign out_overflow  = out_ovf_q;
  assign out_underflow = out_unf_q;
  assign out_invalid   = out_inv_q;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// -----------------------------------------------------------------------------
// tb_fp_addsub_pipe
//   Directed bench for fp_addsub_pipe at the default 8/23/4 configuration.
//   A value-level model predicts every result; hand-computed vectors pin the
//   model. One negedge process scoreboards outputs, handshake and stall hold.
// -----------------------------------------------------------------------------
module tb_fp_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_sub = 1'b0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [3:0]  out_tag;
  logic        out_overflow, out_underflow, out_invalid;

  always #5 clk = ~clk;

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .in_sub        (in_sub),
    .in_tag        (in_tag),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_tag       (out_tag),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow),
    .out_invalid   (out_invalid)
  );

  int tot = 0;
  int bad = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tot++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Value-level model: significands scaled by 4 (two guard bits), little
  // operand shifted with its low bits discarded, result truncated.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input bit sub,
                                output logic [31:0] r, output bit ov, output bit un, output bit inv);
    bit     sa, sb, s, a_is_big;
    int     ea, eb, ma, mb, e_big, d, p, e;
    longint qa, qb, qbig, qlit, v, mant;
    sa = a[31]; sb = b[31] ^ sub;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    ma = int'(a[22:0]);  mb = int'(b[22:0]);
    r = '0; ov = 0; un = 0; inv = 0;
    if ((ea == 255 && ma != 0) || (eb == 255 && mb != 0)) begin
      r = 32'h7FC00000; inv = 1;
    end else if (ea == 255 && eb == 255) begin
      if (sa != sb) begin r = 32'h7FC00000; inv = 1; end
      else r = {sa, 8'hFF, 23'd0};
    end else if (ea == 255) begin
      r = {sa, 8'hFF, 23'd0};
    end else if (eb == 255) begin
      r = {sb, 8'hFF, 23'd0};
    end else if (ea == 0 && eb == 0) begin
      r = {sa & sb, 31'd0};
    end else if (ea == 0) begin
      r = {sb, b[30:0]};
    end else if (eb == 0) begin
      r = {sa, a[30:0]};
    end else begin
      qa = (longint'(ma) + 64'd8388608) * 4;
      qb = (longint'(mb) + 64'd8388608) * 4;
      a_is_big = (ea > eb) || (ea == eb && ma >= mb);
      qbig  = a_is_big ? qa : qb;
      qlit  = a_is_big ? qb : qa;
      e_big = a_is_big ? ea : eb;
      s     = a_is_big ? sa : sb;
      d     = a_is_big ? ea - eb : eb - ea;
      if (d >= 26) qlit = 0;
      else qlit = qlit >> d;
      v = (sa == sb) ? qbig + qlit : qbig - qlit;
      if (v == 0) begin
        r = '0;
      end else begin
        p = 0;
        for (int i = 0; i < 40; i++) if (v[i]) p = i;
        e = e_big + p - 25;
        mant = (p > 25) ? (v >> 1) : (v << (25 - p));
        if (e >= 255) begin
          r = {s, 8'hFF, 23'd0}; ov = 1;
        end else if (e <= 0) begin
          r = '0; un = 1;
        end else begin
          r = {s, 8'(e), 23'(mant >> 2)};
        end
      end
    end
  endfunction

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] r;
    logic [2:0]  f;     // {overflow, underflow, invalid}
    bit          lat;   // check 3-cycle latency
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  // Hand expectations for the op currently presented.
  logic [31:0] cur_hr;
  logic [2:0]  cur_hf;
  bit          cur_lat;

  // Scoreboard, handshake and stall-hold checks.
  bit          stalled_prev = 0;
  logic [31:0] held_res;
  logic [3:0]  held_tag;
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] m_r;
    bit          m_ov, m_un, m_inv;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      stalled_prev = 0;
    end else begin
      check("in_ready", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
      if (stalled_prev) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_result", out_result, held_res);
        check("hold_tag", {28'd0, out_tag}, {28'd0, held_tag});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tot++; bad++;
          $display("FAIL unexpected_output: out_valid=1 tag=%0d required out_valid=0", out_tag);
        end else begin
          e = exp_q.pop_front();
          check("tag", {28'd0, out_tag}, {28'd0, e.tag});
          check("result", out_result, e.r);
          check("flags", {29'd0, out_overflow, out_underflow, out_invalid}, {29'd0, e.f});
          if (e.lat) check("latency", cyc - e.cyc, 32'd3);
        end
      end
      stalled_prev = out_valid && !out_ready;
      held_res = out_result;
      held_tag = out_tag;
      if (in_valid && in_ready) begin
        model(in_a, in_b, in_sub, m_r, m_ov, m_un, m_inv);
        check("model_pin_result", m_r, cur_hr);
        check("model_pin_flags", {29'd0, m_ov, m_un, m_inv}, {29'd0, cur_hf});
        e.tag = in_tag; e.r = m_r; e.f = {m_ov, m_un, m_inv};
        e.lat = cur_lat; e.cyc = cyc;
        exp_q.push_back(e);
      end
    end
  end

  // Present one op and hold it until accepted; returns #1 after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit sub,
                       input logic [3:0] tag, input logic [31:0] hr, input logic [2:0] hf,
                       input bit lat);
    bit acc;
    in_a = a; in_b = b; in_sub = sub; in_tag = tag;
    cur_hr = hr; cur_hf = hf; cur_lat = lat;
    in_valid = 1'b1;
    acc = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin acc = 1; break; end
    end
    check("accept_timeout", {31'd0, acc}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) @(negedge clk);
    check("drain_timeout", exp_q.size(), 32'd0);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
  endtask

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] r;
    logic [2:0]  f;
  } vec_t;

  vec_t vecs [18] = '{
    '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000},  // 3-1
    '{32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 3'b000},  // cancellation
    '{32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 3'b000},  // d=30 shifted out
    '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000},  // truncated guard
    '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b100},  // overflow
    '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b001},  // inf-inf
    '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000},  // single inf
    '{32'h00800000, 32'h00C00000, 1'b1, 32'h00000000, 3'b010},  // underflow
    '{32'h00000000, 32'h40400000, 1'b1, 32'hC0400000, 3'b000},  // one zero
    '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000},  // -0 + -0
    '{32'h80000000, 32'h80000000, 1'b1, 32'h00000000, 3'b000},  // -0 - -0
    '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b001},  // NaN in
    '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000},  // denormal flushed
    '{32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 3'b000},  // carry
    '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000},  // 1+2
    '{32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 3'b000},  // -2+1
    '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 3'b000},  // 1-2, B bigger
    '{32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000, 3'b000}   // inf+inf
  };

  int bp_idx [6] = '{0, 13, 14, 15, 4, 6};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state.
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_tag", {28'd0, out_tag}, 32'd0);
    check("rst_flags", {29'd0, out_overflow, out_underflow, out_invalid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Basic add with latency check.
    issue(32'h3F800000, 32'h3F800000, 1'b0, 4'd5, 32'h40000000, 3'b000, 1'b1);
    drain();

    // Directed vectors, back to back.
    for (int i = 0; i < 18; i++)
      issue(vecs[i].a, vecs[i].b, vecs[i].sub, 4'(i), vecs[i].r, vecs[i].f, 1'b1);
    drain();

    // Backpressure: 6 ops, out_ready low for 4 cycles mid-stream.
    fork
      begin
        for (int i = 0; i < 6; i++)
          issue(vecs[bp_idx[i]].a, vecs[bp_idx[i]].b, vecs[bp_idx[i]].sub, 4'(i),
                vecs[bp_idx[i]].r, vecs[bp_idx[i]].f, 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two ops in flight; they must never emerge.
    issue(vecs[0].a, vecs[0].b, vecs[0].sub, 4'd12, vecs[0].r, vecs[0].f, 1'b0);
    issue(vecs[4].a, vecs[4].b, vecs[4].sub, 4'd13, vecs[4].r, vecs[4].f, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_flush_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    issue(32'h3FC00000, 32'h3FC00000, 1'b0, 4'd9, 32'h40400000, 3'b000, 1'b1);
    drain();
    repeat (6) @(negedge clk);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule

// File: doc/fp_addsub_pipe.md
Name: fp_addsub_pipe

Overview:
Pipelined, parametrised IEEE-754-style floating-point adder/subtractor for the Maxnet datapath. It replaces the single-cycle combinational adder with a 3-stage valid/ready pipeline and adds the following:
- runtime add/sub mode
- correct hidden-bit arithmetic, alignment and renormalisation
- special-value handling and sticky-free status flags
- a pass-through tag so neuron indices travel with their results

Parameters:
EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1)
MAN_W, 23, stored mantissa width (hidden bit not stored)
TAG_W, 4, width of opaque tag carried alongside each operation

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operand pair presented
in_ready  output  1  pipeline can accept operands this cycle
in_a  input  1+EXP_W+MAN_W  operand A {sign, exp, man}
in_b  input  1+EXP_W+MAN_W  operand B
in_sub  input  1  0: A+B, 1: A-B (B sign inverted at input)
in_tag  input  TAG_W  tag returned with result
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_result  output  1+EXP_W+MAN_W  packed result
out_tag  output  TAG_W  tag of this result
out_overflow  output  1  result exponent saturated to infinity (finite inputs)
out_underflow  output  1  nonzero result flushed to +0
out_invalid  output  1  NaN input or inf-inf; result is canonical NaN

Behaviour:
- Reset (rst_n=0 at clk edge): all stage valid bits cleared. out_valid=0, out_result=0, out_tag=0, all flags 0. In-flight operations are discarded. in_ready=1 in the cycle after reset.
- Pipeline advance: adv = !out_valid | out_ready. All three stages shift together when adv=1 and hold otherwise. in_ready = adv. A transfer occurs when in_valid & in_ready.
- Latency and throughput: 3 cycles from accepted input to out_valid with no backpressure. Throughput is 1 op/cycle.
- Output hold: while out_valid=1 & out_ready=0, out_* hold stable. Bubbles propagate as valid=0.
- Stage 1, unpack/swap/align:
  - beff = in_b ^ {in_sub, 0...}.
  - exp==0 is treated as zero; denormals are flushed and the mantissa is ignored.
  - Hidden bit = 1 for exp != 0.
  - big = operand with larger {exp, man}; ties pick A.
  - d = exp_big - exp_little. The little mantissa (MAN_W+1 bits plus 2 guard bits) is shifted right by d. If d >= MAN_W+3, the little mantissa becomes 0.
- Stage 2, add/sub:
  - Same signs: add, MAN_W+4-bit result including carry.
  - Different signs: big - little, never negative.
  - Result sign = big sign.
- Stage 3, normalise/pack:
  - Carry set: shift right 1, exp+1.
  - Otherwise: leading-zero count lz, shift left lz, exp-lz.
  - Rounding is truncation (toward zero); guard bits are dropped.
  - Mantissa result 0: output +0 (sign 0), no flags.
  - Computed exp >= 2^EXP_W-1: output {sign, all-ones, 0}, out_overflow=1.
  - Computed exp <= 0 with nonzero mantissa: output +0, out_underflow=1.
- Specials (decided in stage 1, carried as bypass):
  - Any NaN (exp all-ones, man != 0): output 0x7FC00000 (generic: {0, all-ones, 1, 0...}), out_invalid=1.
  - inf + (-inf) after sub-mode inversion: same NaN, out_invalid=1.
  - Single inf: output that inf, with its effective sign. Flags 0 (not overflow).
  - Both zero: +0 unless both effective signs negative, which gives -0.
  - One zero: output the other operand unchanged (effective sign).
- Flags are per-result and valid only with out_valid. Tag is carried unchanged.

Test Plan:
- Basic add: 0x3F800000 + 0x3F800000, sub=0, tag=5 -> after 3 cycles 0x40000000, tag 5, flags 0.
- Subtract and cancellation: 0x40400000 - 0x3F800000 -> 0x40000000. Then 0x3F800000 + 0xBF800000 -> 0x00000000, no flags.
- Alignment/truncation: 0x3F800000 + 0x30800000 (d=30 > 25) -> 0x3F800000. Then 0x3F800000 + 0x33800000 -> 0x3F800000 (truncated).
- Specials: 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000 with overflow=1. 0x7F800000 - 0x7F800000 -> 0x7FC00000 with invalid=1. 0xFF800000 + 0x3F800000 -> 0xFF800000 with flags 0.
- Backpressure: stream 6 ops back-to-back, hold out_ready=0 for 4 cycles mid-stream.
  - in_ready must drop while out_valid & !out_ready.
  - No result may be lost, duplicated or reordered (check by tag 0..5).
  - out_result must stay stable while stalled.
- Reset mid-operation: 2 ops in flight, assert rst_n=0 for 1 cycle -> out_valid=0 next cycle. Those results never appear. A new op issued after reset emerges 3 cycles later with the correct value.
